muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 118 +++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 32 shift-add or restoring steps plus one sign fix-up cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, rd_q, rd_d, rd_out_q, rd_out_d;
  logic [2:0] op_q, op_d;
  logic fin_q, fin_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [XLEN-1:0] m_q, m_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag, div_diff, quo, rem, fix;
  logic [XLEN:0] mul_sum, div_sh;
  logic div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  assign sgn_a = funct3[2] ? ~funct3[0] : funct3[1] ^ funct3[0];
  assign sgn_b = funct3[2] ? ~funct3[0] : funct3 == 3'b001;
  assign neg_a = sgn_a & rs1_data[XLEN-1];
  assign neg_b = sgn_b & rs2_data[XLEN-1];
  assign a_mag = neg_a ? -rs1_data : rs1_data;
  assign b_mag = neg_b ? -rs2_data : rs2_data;
  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}, m_q holds the other operand.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign div_diff = div_sh[XLEN-1:0] - m_q;
  assign div_next = {div_ge ? div_diff : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = dz_q ? '1 : (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix  = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fin_d = fin_q;
    op_d = op_q;
    rd_d = rd_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    m_d = m_q;
    acc_d = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        cnt_d = '0;
        fin_d = 1'b0;
        op_d = funct3;
        rd_d = rd_in;
        sa_d = neg_a;
        sb_d = neg_b;
        dz_d = rs2_data == '0;
        m_d = funct3[2] ? b_mag : a_mag;
        acc_d = {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
      end
      CALC: if (!fin_q) begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        fin_d = cnt_q == 5'd31;
      end else begin
        result_d = fix;
        rd_out_d = rd_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fin_q <= 1'b0;
      op_q <= '0;
      rd_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      m_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fin_q <= fin_d;
      op_q <= op_d;
      rd_q <= rd_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      dz_q <= dz_d;
      m_q <= m_d;
      acc_q <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 0, rst = 0, start = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0;
  logic [4:0] rd_in = 0;
  logic busy, done;
  logic [31:0] result;
  logic [4:0] rd_out;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] rdo, output int lat, output int width);
    launch(f, a, b, rd);
    lat = -1; width = 0; res = 'x; rdo = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (lat < 0) begin lat = k; res = result; rdo = rd_out; end
        width++;
      end
    end
  endtask
  task automatic test_reset();
    #1 rst = 1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
    checks++; if (rd_out !== 5'h0) $display("FAIL reset_rd got %0d want 0", rd_out); else passed++;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic test_directed();
    logic [2:0] f[12] = '{0, 1, 3, 2, 4, 6, 5, 7, 4, 7, 4, 6};
    logic [31:0] a[12] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                           32'd7, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                           32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                           32'd3, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    logic [4:0] rdo;
    int lat, width;
    for (int i = 0; i < 12; i++) begin
      run_op(f[i], a[i], b[i], (i == 0) ? 5'd5 : 5'(i * 3), res, rdo, lat, width);
      checks++; if (res !== e[i]) $display("FAIL dir%0d_result got %h want %h", i, res, e[i]); else passed++;
      checks++; if (rdo !== ((i == 0) ? 5'd5 : 5'(i * 3))) $display("FAIL dir%0d_rd got %0d want %0d", i, rdo, (i == 0) ? 5 : i * 3); else passed++;
      checks++; if (lat != 33) $display("FAIL dir%0d_latency got %0d want 33", i, lat); else passed++;
      checks++; if (width != 1) $display("FAIL dir%0d_done_width got %0d want 1", i, width); else passed++;
    end
  endtask
  task automatic test_random();
    logic [31:0] a, b, res;
    logic [2:0] f;
    logic [4:0] rd, rdo;
    int lat, width;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom); a = pick(); b = pick(); rd = 5'($urandom);
      run_op(f, a, b, rd, res, rdo, lat, width);
      checks++; if (res !== model(f, a, b)) $display("FAIL rand%0d_op%0d a=%h b=%h got %h want %h", i, f, a, b, res, model(f, a, b)); else passed++;
      checks++; if (rdo !== rd || lat != 33 || width != 1) $display("FAIL rand%0d_handshake rd=%0d/%0d lat=%0d width=%0d want lat 33 width 1", i, rdo, rd, lat, width); else passed++;
    end
  endtask
  task automatic test_ignore_start();
    logic [31:0] res = 'x;
    logic [4:0] rdo = 'x;
    int lat = -1, width = 0;
    launch(3'd4, 32'd100, 32'd7, 5'd9);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (lat < 0) begin lat = k; res = result; rdo = rd_out; end
        width++;
      end
      if (k == 35) begin
        checks++; if (busy !== 1'b0) $display("FAIL ignore_queued busy got %0b want 0", busy); else passed++;
      end
      if (k == 9 || k == 33) begin start = 1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd1; end
      if (k == 10 || k == 34) start = 0;
    end
    checks++; if (res !== model(3'd4, 32'd100, 32'd7)) $display("FAIL ignore_result got %h want %h", res, model(3'd4, 32'd100, 32'd7)); else passed++;
    checks++; if (rdo !== 5'd9) $display("FAIL ignore_rd got %0d want 9", rdo); else passed++;
    checks++; if (lat != 33 || width != 1) $display("FAIL ignore_timing lat=%0d width=%0d want 33/1", lat, width); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [31:0] a1 = pick(), b1 = pick(), a2 = pick(), b2 = $urandom_range(1, 99);
    logic [31:0] r1 = 'x, r2 = 'x;
    int l1 = -1, l2 = -1;
    launch(3'd3, a1, b1, 5'd11);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      if (done && l1 < 0) begin l1 = k; r1 = result; end
    end
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle busy got %0b want 0", busy); else passed++;
    start = 1; funct3 = 3'd6; rs1_data = a2; rs2_data = b2; rd_in = 5'd12;
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done && l2 < 0) begin l2 = k; r2 = result; end
    end
    checks++; if (r1 !== model(3'd3, a1, b1) || l1 != 33) $display("FAIL b2b_first got %h lat %0d want %h lat 33", r1, l1, model(3'd3, a1, b1)); else passed++;
    checks++; if (r2 !== model(3'd6, a2, b2) || l2 != 33) $display("FAIL b2b_second got %h lat %0d want %h lat 33", r2, l2, model(3'd6, a2, b2)); else passed++;
  endtask
  task automatic test_reset_abort();
    logic [31:0] res;
    logic [4:0] rdo;
    int lat, width, stray = 0;
    run_op(3'd0, 32'd6, 32'd7, 5'd3, res, rdo, lat, width);
    checks++; if (res !== 32'd42) $display("FAIL abort_pre got %h want 2a", res); else passed++;
    launch(3'd4, 32'd1000, 32'd3, 5'd4);
    repeat (15) @(posedge clk);
    @(negedge clk); #2 rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_ctrl busy=%0b done=%0b want 0/0", busy, done); else passed++;
    checks++; if (result !== 32'h0 || rd_out !== 5'h0) $display("FAIL abort_outputs result=%h rd=%0d want 0/0", result, rd_out); else passed++;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) stray++;
    end
    checks++; if (stray != 0) $display("FAIL abort_no_done got %0d pulses want 0", stray); else passed++;
    run_op(3'd0, 32'd3, 32'd4, 5'd7, res, rdo, lat, width);
    checks++; if (res !== 32'd12 || rdo !== 5'd7 || lat != 33) $display("FAIL abort_after got %h rd %0d lat %0d want 0000000c rd 7 lat 33", res, rdo, lat); else passed++;
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
